axis_uart_tx: RTL and testbench
===============================

AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the i_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 57600, meaning the UART bit rate in bit/s.
REQ-003 The block SHALL have parameter FIFO_AW, default 4, meaning log2 of FIFO depth (DEPTH = 2**FIFO_AW).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port i_tdata, input, 8 bits: stream byte.
REQ-007 The block SHALL have port i_tlast, input, 1 bit: marks the last byte of a packet.
REQ-008 The block SHALL have port i_tvalid, input, 1 bit: stream valid.
REQ-009 The block SHALL have port o_tready, output, 1 bit: stream ready.
REQ-010 The block SHALL have port o_uart_tx, output, 1 bit: serial line, 8N1, idle high.
REQ-011 The block SHALL have port o_busy, output, 1 bit: FIFO non-empty or frame in progress.
REQ-012 The block SHALL have port o_pkt_done, output, 1 bit: one-cycle pulse at completion of a tlast byte's frame.

Function
REQ-013 The block SHALL compute DIV = CLK_FREQ/BAUD_RATE with integer truncation; DIV < 2 is a configuration error and SHALL be flagged at elaboration.
REQ-014 The block SHALL accept a byte (with its tlast flag) on every rising edge where i_tvalid and o_tready are both high, writing it into a DEPTH-entry FIFO of 9-bit entries.
REQ-015 The block SHALL drive o_tready = !full combinationally; o_tready SHALL NOT depend on i_tvalid.
REQ-016 The FIFO SHALL handle simultaneous push and pop in one cycle with the occupancy count unchanged; a pop in a full cycle SHALL NOT raise o_tready until the following cycle.
REQ-017 The FIFO read and write pointers SHALL wrap modulo DEPTH; the occupancy count SHALL be FIFO_AW+1 bits wide.
REQ-018 The transmitter FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry into the shift register and enter START.
REQ-020 In START, o_uart_tx SHALL be 0 for exactly DIV cycles, after which the FSM SHALL enter DATA.
REQ-021 In DATA, the FSM SHALL send 8 bits LSB first, each for DIV cycles, using a 3-bit bit counter, then enter STOP.
REQ-022 In STOP, o_uart_tx SHALL be 1 for DIV cycles; at the end of STOP, the FSM SHALL pop and enter START if the FIFO is non-empty, otherwise enter IDLE.
REQ-023 Back-to-back frames SHALL therefore be exactly 10*DIV cycles each, with no idle gap.
REQ-024 With the block idle and the FIFO empty, a byte accepted at edge N SHALL be popped at edge N+1, and o_uart_tx SHALL go low after edge N+2.
REQ-025 o_uart_tx SHALL be registered and glitch-free.
REQ-026 o_pkt_done SHALL pulse high for exactly one cycle on the cycle the FSM leaves STOP for a byte whose tlast flag was 1; otherwise o_pkt_done SHALL be 0.
REQ-027 o_busy SHALL be 1 whenever the FSM is not in IDLE or the FIFO is non-empty.

Reset
REQ-028 While i_rst is high: o_uart_tx = 1, o_tready = 0, o_busy = 0, o_pkt_done = 0, the FSM is in IDLE, the FIFO is empty, and all counters are 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame (line high from the next edge) and discard all FIFO contents; no partial frame SHALL resume.
REQ-030 o_tready SHALL rise on the first edge after i_rst deasserts.

Verification (CLK_FREQ=16, BAUD_RATE=1, DIV=16, FIFO_AW=4)
REQ-031 The bench SHALL cover: single byte 0x55 accepted at edge N -> line low over cycles N+2..N+17, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, stop high 16 cycles, then o_busy=0.
REQ-032 The bench SHALL cover: bytes 0x00, 0xFF, 0xA5 offered back-to-back -> 480 contiguous frame cycles with correct bit patterns and no idle gap.
REQ-033 The bench SHALL cover: i_tvalid held high with an incrementing pattern -> exactly 17 bytes accepted before o_tready first drops (16 in FIFO, 1 in shifter); o_tready re-rises exactly one cycle after each subsequent pop; no byte is lost or duplicated.
REQ-034 The bench SHALL cover: 4-byte packet with i_tlast on byte 3 only -> exactly one o_pkt_done pulse, at the end of byte 3's stop bit.
REQ-035 The bench SHALL cover: i_rst asserted during DATA bit 4 -> o_uart_tx=1 and o_busy=0 after the next edge; a byte 0x3C sent after release transmits correctly.
REQ-036 The bench SHALL cover: i_tvalid high while o_tready is low -> no acceptance, FIFO count unchanged, and i_tdata changes ignored.

Source files
------------

// File: rtl/axis_uart_tx.sv
// AXI-Stream byte input to 8N1 UART transmitter with a small FIFO.
// Frames go out back to back; o_pkt_done marks the end of each tlast byte's frame.
module axis_uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 57600,
  parameter int FIFO_AW   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_pkt_done
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int CW    = FIFO_AW + 1;

  if (DIV < 2) begin : g_div_err
    $error("axis_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 last_q, last_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 rdy_q;
  logic [FIFO_AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [8:0]           mem_q [DEPTH];
  logic                 full, empty, push, pop, baud_end;
  logic [8:0]           head;

  // rdy_q holds tready low through reset and releases it on the first edge after.
  assign full       = (cnt_q == CW'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign o_tready   = rdy_q & ~full & ~i_rst;
  assign push       = i_tvalid & o_tready;
  assign head       = mem_q[rd_q];
  assign baud_end   = (baud_q == BW'(DIV - 1));
  assign o_uart_tx  = tx_q;
  assign o_busy     = ~i_rst & ((state_q != IDLE) | ~empty);
  assign o_pkt_done = done_q & ~i_rst;

  always_comb begin
    wr_d  = wr_q + FIFO_AW'(push);
    rd_d  = rd_q + FIFO_AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head[7:0];
          last_d  = head[8];
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          done_d = last_q;
          // Chain straight into the next start bit so frames have no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head[7:0];
            last_d  = head[8];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state one cycle later, from a flop, so it never glitches.
  always_comb begin
    tx_d = 1'b1;
    if (state_q == START)     tx_d = 1'b0;
    else if (state_q == DATA) tx_d = shift_q[0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      rdy_q   <= 1'b1;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= {i_tlast, i_tdata};
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx at DIV=16: a UART receiver model plus accept-queue scoreboard,
// a vector table of single frames, and directed multi-cycle sequences.
module tb_axis_uart_tx;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] tdata = '0;
  logic       tlast = 1'b0, tvalid = 1'b0;
  logic       tready, tx, busy, pkt_done;

  always #5 clk = ~clk;

  axis_uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .FIFO_AW(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .o_tready(tready), .o_uart_tx(tx), .o_busy(busy), .o_pkt_done(pkt_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       lst;
    logic [9:0] frame;  // bit i = i-th line bit: start, d0..d7, stop
  } vec_t;

  int         total = 0, bad = 0, cyc = 0, acc_cnt = 0;
  logic [8:0] exp_q[$];
  bit         dec_on = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Accept monitor: every handshake lands in the expected-frame queue.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) exp_q.delete();
    else if (tvalid && tready) begin
      exp_q.push_back({tlast, tdata});
      acc_cnt++;
    end
  end

  // UART receiver model: 160 samples per frame, checked against the queue head.
  initial begin
    int k, frm_err, pd_err;
    logic [8:0] cur;
    logic ev;
    k = 0; frm_err = 0; pd_err = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) dec_on = 0;
      else if (!dec_on) begin
        chk("pkt_done_idle", pkt_done, 0);
        if (!tx) begin
          dec_on = 1; k = 0; frm_err = 0; pd_err = 0;
          chk("frame_expected", exp_q.size() != 0, 1);
          cur = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h0;
        end
      end
      if (dec_on) begin
        if (k < 16)       ev = 1'b0;
        else if (k >= 144) ev = 1'b1;
        else              ev = cur[(k / 16) - 1];
        if (tx !== ev) frm_err++;
        if (pkt_done !== ((k == 159) && cur[8])) pd_err++;
        k++;
        if (k == 160) begin
          chk("frame_bits", frm_err, 0);
          chk("frame_pkt_done", pd_err, 0);
          dec_on = 0;
        end
      end
    end
  end

  task automatic wait_idle(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk); #1;
      ok = !busy && !dec_on;
    end
    chk("idle_wait", ok, 1);
  endtask

  task automatic apply_vec(input vec_t v);
    logic [9:0] line = '0;
    logic l1 = 1'b0, l2 = 1'b1, busy_end = 1'b1;
    int pd_cnt = 0, pd_at = -1;
    wait_idle(400);
    @(posedge clk); #1;
    tvalid = 1'b1; tdata = v.data; tlast = v.lst;
    @(negedge clk); chk("vec_rdy", tready, 1);
    @(posedge clk); #1;  // edge N
    tvalid = 1'b0; tlast = 1'b0;
    for (int j = 0; j < 164; j++) begin
      @(negedge clk);
      if (j == 1) l1 = tx;
      if (j == 2) l2 = tx;
      if (j >= 2 && j < 162 && ((j - 2) % 16) == 8) line[(j - 2) / 16] = tx;
      if (pkt_done) begin pd_cnt++; pd_at = j; end
      if (j == 162) busy_end = busy;
    end
    chk("vec_line_n1", l1, 1);
    chk("vec_line_n2", l2, 0);
    chk("vec_frame", line, v.frame);
    chk("vec_pd_cnt", pd_cnt, v.lst);
    chk("vec_pd_at", pd_at, v.lst ? 161 : -1);
    chk("vec_busy_end", busy_end, 0);
  endtask

  initial begin
    vec_t tbl[4];
    logic [2:0][9:0] fr;
    int n0, d, err, pc, pat, acc, hi, last_hi, drop_c, acc0;
    bit dropped, prev, r, ok;
    logic [7:0] nv;

    tbl[0] = '{data: 8'h55, lst: 1'b0, frame: 10'h2AA};
    tbl[1] = '{data: 8'h00, lst: 1'b1, frame: 10'h200};
    tbl[2] = '{data: 8'hFF, lst: 1'b0, frame: 10'h3FE};
    tbl[3] = '{data: 8'h3C, lst: 1'b1, frame: 10'h278};

    // Reset state and tready release timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_rdy", tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt", pkt_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("rdy_release_cycle", tready, 0);
    @(negedge clk); chk("rdy_after_edge", tready, 1);

    for (int i = 0; i < 4; i++) apply_vec(tbl[i]);

    // Back-to-back 0x00, 0xFF, 0xA5: 480 contiguous frame cycles
    fr = {10'h34A, 10'h3FE, 10'h200};
    wait_idle(400);
    @(posedge clk); #1 tvalid = 1'b1; tdata = 8'h00;
    @(posedge clk); #1 n0 = cyc; tdata = 8'hFF;
    @(posedge clk); #1 tdata = 8'hA5;
    @(posedge clk); #1 tvalid = 1'b0;
    err = 0; d = 0;
    for (int i = 0; i < 600 && d < 482; i++) begin
      @(negedge clk);
      d = cyc - n0;
      if (d >= 2 && d <= 481) begin
        if (tx !== fr[(d - 2) / 160][((d - 2) % 160) / 16]) err++;
      end
      if (d == 482) begin
        chk("b2b_line_after", tx, 1);
        chk("b2b_busy_after", busy, 0);
      end
    end
    chk("b2b_bits", err, 0);

    // 4-byte packet, tlast on the third byte
    wait_idle(400);
    @(posedge clk); #1 tvalid = 1'b1; tdata = 8'h11; tlast = 1'b0;
    @(posedge clk); #1 n0 = cyc; tdata = 8'h22;
    @(posedge clk); #1 tdata = 8'h33; tlast = 1'b1;
    @(posedge clk); #1 tdata = 8'h44; tlast = 1'b0;
    @(posedge clk); #1 tvalid = 1'b0;
    pc = 0; pat = -1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (pkt_done) begin pc++; pat = cyc - n0; end
    end
    chk("pkt_pulses", pc, 1);
    chk("pkt_at", pat, 481);

    // Reset during DATA bit 4 of 0xC3, then 0x3C must go out cleanly
    wait_idle(400);
    @(posedge clk); #1 tvalid = 1'b1; tdata = 8'hC3;
    @(posedge clk); #1 n0 = cyc; tvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (cyc - n0 == 85);
    end
    chk("mid_reach", ok, 1);
    rst = 1'b1;
    @(negedge clk); chk("mid_bit4", tx, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", tready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("mid_rdy_release", tready, 0);
    @(negedge clk); chk("mid_rdy_up", tready, 1);
    apply_vec(tbl[3]);

    // Fill: 17 accepts before tready drops, then single-cycle reopen per pop
    wait_idle(400);
    @(posedge clk); #1;
    acc0 = acc_cnt; nv = 8'h00;
    tvalid = 1'b1; tdata = nv; tlast = 1'b0;
    acc = 0; hi = 0; last_hi = -1; drop_c = 0; dropped = 0; prev = 0;
    for (int i = 0; i < 1200 && hi < 3; i++) begin
      @(negedge clk);
      r = tready;
      if (!dropped) begin
        if (r) acc++;
        else begin
          dropped = 1; drop_c = cyc;
          chk("fill_count", acc, 17);
        end
      end else begin
        if (prev) chk("rdy_one_cycle", r, 0);
        if (r) begin
          chk("rdy_gap", cyc - ((last_hi < 0) ? drop_c : last_hi), (last_hi < 0) ? 145 : 160);
          last_hi = cyc; hi++;
        end
      end
      prev = r;
      if (!r) tdata = 8'($urandom);  // must be ignored while not ready
      @(posedge clk); #1;
      if (r) nv++;
      tdata = nv;
    end
    tvalid = 1'b0;
    chk("fill_reopens", hi, 3);
    wait_idle(4000);
    chk("fill_accepted", acc_cnt - acc0, 20);
    chk("fill_queue_empty", exp_q.size(), 0);

    // Random traffic against the receiver model
    acc0 = acc_cnt;
    for (int i = 0; i < 8000 && (acc_cnt - acc0) < 25; i++) begin
      @(posedge clk); #1;
      tvalid = ($urandom_range(0, 3) != 0);
      tdata  = 8'($urandom);
      tlast  = 1'($urandom_range(0, 1));
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("rand_accepted", (acc_cnt - acc0) >= 25, 1);
    wait_idle(6000);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
